mips_regwrite_arbiter: RTL and testbench

Shares the single write port of the 32x32 MIPS register file between three writeback sources: ALU results, memory loads and the multicycle multiply/divide unit. Each cycle it grants at most one requester over a valid/ready handshake and registers the winning register number and data into an output stage that drives the register file write port directly. It also suppresses writes to `$0` and keeps a saturating contention counter for performance analysis.

---
 rtl/mips_regwrite_arbiter.sv | 136 +++++++++++++
 tb/tb_mips_regwrite_arbiter.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/mips_regwrite_arbiter.sv
// rtl/mips_regwrite_arbiter.sv - three-source register file write port arbiter (option: MIPS_ARB_FIXED_PRIORITY_EN)
module mips_regwrite_arbiter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             alu_valid,
    input  logic [4:0]       alu_reg,
    input  logic [31:0]      alu_data,
    output logic             alu_ready,
    input  logic             mem_valid,
    input  logic [4:0]       mem_reg,
    input  logic [31:0]      mem_data,
    output logic             mem_ready,
    input  logic             md_valid,
    input  logic [4:0]       md_reg,
    input  logic [31:0]      md_data,
    output logic             md_ready,
    output logic [4:0]       write_reg,
    output logic [31:0]      write_data,
    output logic             signal_reg_write,
    output logic [CNT_W-1:0] conflict_cycles
);

    logic [2:0]       valid_vec;
    logic [2:0]       grant;
    logic [2:0]       grant_ok;
    logic             multi_req;
    logic [4:0]       write_reg_q, write_reg_d;
    logic [31:0]      write_data_q, write_data_d;
    logic             signal_reg_write_q, signal_reg_write_d;
    logic [CNT_W-1:0] conflict_cycles_q, conflict_cycles_d;

    assign valid_vec = {md_valid, mem_valid, alu_valid};
    assign multi_req = (alu_valid & mem_valid) | (alu_valid & md_valid) | (mem_valid & md_valid);

`ifdef MIPS_ARB_FIXED_PRIORITY_EN
    always_comb begin
        grant    = '0;
        grant[1] = mem_valid;
        grant[0] = alu_valid & ~mem_valid;
        grant[2] = md_valid & ~mem_valid & ~alu_valid;
    end
`else
    logic [1:0] last_grant_q, last_grant_d;
    logic [1:0] start_idx;
    logic [2:0] idx;
    logic       found;

    // Search begins one past the last winner, wrapping MD back to ALU.
    always_comb begin
        grant     = '0;
        found     = 1'b0;
        idx       = '0;
        start_idx = (last_grant_q == 2'd2) ? 2'd0 : last_grant_q + 2'd1;
        for (int i = 0; i < 3; i++) begin
            idx = {1'b0, start_idx} + 3'(i);
            if (idx >= 3'd3) begin
                idx = idx - 3'd3;
            end
            if (!found && valid_vec[idx[1:0]]) begin
                grant[idx[1:0]] = 1'b1;
                found           = 1'b1;
            end
        end
    end

    always_comb begin
        last_grant_d = last_grant_q;
        if (grant_ok[0]) begin
            last_grant_d = 2'd0;
        end else if (grant_ok[1]) begin
            last_grant_d = 2'd1;
        end else if (grant_ok[2]) begin
            last_grant_d = 2'd2;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant_q <= 2'd2;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end
`endif

    assign grant_ok  = reset ? 3'b000 : grant;
    assign alu_ready = grant_ok[0];
    assign mem_ready = grant_ok[1];
    assign md_ready  = grant_ok[2];

    // A $0 grant still completes the handshake and loads the data, only the enable is dropped.
    always_comb begin
        write_reg_d        = write_reg_q;
        write_data_d       = write_data_q;
        signal_reg_write_d = 1'b0;
        if (grant_ok[0]) begin
            write_reg_d  = alu_reg;
            write_data_d = alu_data;
        end else if (grant_ok[1]) begin
            write_reg_d  = mem_reg;
            write_data_d = mem_data;
        end else if (grant_ok[2]) begin
            write_reg_d  = md_reg;
            write_data_d = md_data;
        end
        if (|grant_ok) begin
            signal_reg_write_d = (write_reg_d != 5'd0);
        end
        conflict_cycles_d = conflict_cycles_q;
        if (multi_req && !(&conflict_cycles_q)) begin
            conflict_cycles_d = conflict_cycles_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            write_reg_q        <= '0;
            write_data_q       <= '0;
            signal_reg_write_q <= 1'b0;
            conflict_cycles_q  <= '0;
        end else begin
            write_reg_q        <= write_reg_d;
            write_data_q       <= write_data_d;
            signal_reg_write_q <= signal_reg_write_d;
            conflict_cycles_q  <= conflict_cycles_d;
        end
    end

    assign write_reg        = write_reg_q;
    assign write_data       = write_data_q;
    assign signal_reg_write = signal_reg_write_q;
    assign conflict_cycles  = conflict_cycles_q;

endmodule

// File: tb/tb_mips_regwrite_arbiter.sv
// tb/tb_mips_regwrite_arbiter.sv - directed bench for mips_regwrite_arbiter
module tb_mips_regwrite_arbiter;

    localparam int TB_CNT_W = 4;

    logic                clk;
    logic                reset;
    logic                alu_valid, mem_valid, md_valid;
    logic [4:0]          alu_reg, mem_reg, md_reg;
    logic [31:0]         alu_data, mem_data, md_data;
    logic                alu_ready, mem_ready, md_ready;
    logic [4:0]          write_reg;
    logic [31:0]         write_data;
    logic                signal_reg_write;
    logic [TB_CNT_W-1:0] conflict_cycles;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] rf [32] = '{default: 32'd0};

    mips_regwrite_arbiter #(.CNT_W(TB_CNT_W)) dut (
        .clk(clk), .reset(reset),
        .alu_valid(alu_valid), .alu_reg(alu_reg), .alu_data(alu_data), .alu_ready(alu_ready),
        .mem_valid(mem_valid), .mem_reg(mem_reg), .mem_data(mem_data), .mem_ready(mem_ready),
        .md_valid(md_valid), .md_reg(md_reg), .md_data(md_data), .md_ready(md_ready),
        .write_reg(write_reg), .write_data(write_data), .signal_reg_write(signal_reg_write),
        .conflict_cycles(conflict_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (signal_reg_write) rf[write_reg] <= write_data;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        alu_valid = 1'b0; mem_valid = 1'b0; md_valid = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    function automatic logic [31:0] readies();
        return {29'd0, md_ready, mem_ready, alu_ready};
    endfunction

    initial begin
        logic [31:0] exp_rdy;
        int          exp_idx;
        int          budget;
        bit          alu_done, mem_done;

        alu_reg = 5'd0; alu_data = '0; mem_reg = 5'd0; mem_data = '0;
        md_reg = 5'd0; md_data = '0;
        do_reset();
        check("reset_write_reg", 32'(write_reg), 32'd0);
        check("reset_write_data", write_data, 32'd0);
        check("reset_we", 32'(signal_reg_write), 32'd0);
        check("reset_conflict", 32'(conflict_cycles), 32'd0);

        // Single ALU request
        alu_valid = 1'b1; alu_reg = 5'd5; alu_data = 32'h0000_00AA;
        #1;
        check("single_ready", readies(), 32'b001);
        tick();
        alu_valid = 1'b0;
        check("single_reg", 32'(write_reg), 32'd5);
        check("single_data", write_data, 32'hAA);
        check("single_we", 32'(signal_reg_write), 32'd1);
        tick();
        check("single_we_drop", 32'(signal_reg_write), 32'd0);
        check("single_reg_hold", 32'(write_reg), 32'd5);

        // $0 suppression
        mem_valid = 1'b1; mem_reg = 5'd0; mem_data = 32'hFFFF_FFFF;
        #1;
        check("zero_ready", readies(), 32'b010);
        tick();
        mem_valid = 1'b0;
        check("zero_we", 32'(signal_reg_write), 32'd0);
        check("zero_data", write_data, 32'hFFFF_FFFF);
        tick();
        check("zero_we_after", 32'(signal_reg_write), 32'd0);

        // Round-robin with all three valid
        do_reset();
        alu_valid = 1'b1; alu_reg = 5'd1; alu_data = 32'h101;
        mem_valid = 1'b1; mem_reg = 5'd2; mem_data = 32'h102;
        md_valid  = 1'b1; md_reg  = 5'd3; md_data  = 32'h103;
        for (int i = 0; i < 6; i++) begin
            #1;
`ifdef MIPS_ARB_FIXED_PRIORITY_EN
            exp_idx = 1;
`else
            exp_idx = i % 3;
`endif
            exp_rdy = 32'd1 << exp_idx;
            check($sformatf("rr_ready_%0d", i), readies(), exp_rdy);
            tick();
            check($sformatf("rr_reg_%0d", i), 32'(write_reg), 32'(exp_idx + 1));
        end
        alu_valid = 1'b0; mem_valid = 1'b0; md_valid = 1'b0;
        check("rr_conflict", 32'(conflict_cycles), 32'd6);

        // Same register back to back
        do_reset();
        alu_valid = 1'b1; alu_reg = 5'd7; alu_data = 32'h11;
        mem_valid = 1'b1; mem_reg = 5'd7; mem_data = 32'h22;
        alu_done = 1'b0; mem_done = 1'b0;
        budget = 0;
        while (!(alu_done && mem_done) && budget < 10) begin
            #1;
            if (alu_ready) alu_done = 1'b1;
            if (mem_ready) mem_done = 1'b1;
            exp_rdy = readies();
            tick();
            if (exp_rdy[0]) alu_valid = 1'b0;
            if (exp_rdy[1]) mem_valid = 1'b0;
            budget++;
        end
        check("b2b_budget", 32'(budget < 10), 32'd1);
        check("b2b_cycles", 32'(budget), 32'd2);
        tick();
        tick();
`ifdef MIPS_ARB_FIXED_PRIORITY_EN
        check("b2b_rf7", rf[7], 32'h11);
`else
        check("b2b_rf7", rf[7], 32'h22);
`endif

        // Reset mid-stream
        do_reset();
        alu_valid = 1'b1; mem_valid = 1'b1; md_valid = 1'b1;
        alu_reg = 5'd1; mem_reg = 5'd2; md_reg = 5'd3;
        tick();
        tick();
        reset = 1'b1;
        #1;
        check("mid_ready_in_reset", readies(), 32'd0);
        tick();
        check("mid_reg", 32'(write_reg), 32'd0);
        check("mid_data", write_data, 32'd0);
        check("mid_we", 32'(signal_reg_write), 32'd0);
        check("mid_conflict", 32'(conflict_cycles), 32'd0);
        reset = 1'b0;
        #1;
`ifdef MIPS_ARB_FIXED_PRIORITY_EN
        check("mid_first_grant", readies(), 32'b010);
`else
        check("mid_first_grant", readies(), 32'b001);
`endif
        tick();
        alu_valid = 1'b0; mem_valid = 1'b0; md_valid = 1'b0;

        // Counter saturation with a 4-bit counter
        do_reset();
        alu_valid = 1'b1; mem_valid = 1'b1;
        for (int i = 0; i < 14; i++) tick();
        check("sat_14", 32'(conflict_cycles), 32'd14);
        for (int i = 0; i < 5; i++) tick();
        check("sat_hold", 32'(conflict_cycles), 32'd15);
        alu_valid = 1'b0; mem_valid = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
